// File: rtl/phase_operand_mux.sv
// Per-instruction register-read sequencer: walks NPHASE phases and, in each one,
// registers the source chosen by that phase's select code onto the operand bus.
module phase_operand_mux #(
    parameter  int WIDTH  = 32,
    parameter  int NSRC   = 8,
    parameter  int SELW   = 4,
    parameter  int NPHASE = 3,
    localparam int PW     = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic [NPHASE*SELW-1:0]   sel_bus,
    input  logic [NSRC*WIDTH-1:0]    src_bus,
    output logic                     busy,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [PW-1:0]            out_phase,
    output logic                     done,
    output logic                     bad_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

    localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASE - 1);
    localparam logic [SELW:0] NSRC_CODE  = (SELW + 1)'(NSRC);

    mode_t                   mode_q, mode_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [NPHASE*SELW-1:0]  snap_q, snap_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    valid_q, valid_d;
    logic [PW-1:0]           outPhase_q, outPhase_d;
    logic                    done_q, done_d;
    logic                    bad_q, bad_d;

    logic [SELW-1:0]         code;
    logic [WIDTH-1:0]        srcSel;
    logic                    codeInRange;

    // Decode the current phase's code from the snapshot, then pick the source it names.
    always_comb begin
        code = '0;
        for (int k = 0; k < NPHASE; k++) begin
            if (phase_q == PW'(k)) begin
                code = snap_q[k*SELW +: SELW];
            end
        end
        srcSel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (code == SELW'(i)) begin
                srcSel = src_bus[i*WIDTH +: WIDTH];
            end
        end
        codeInRange = ({1'b0, code} < NSRC_CODE);
    end

    always_comb begin
        mode_d     = mode_q;
        phase_d    = phase_q;
        snap_d     = snap_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        outPhase_d = outPhase_q;
        done_d     = 1'b0;
        bad_d      = 1'b0;

        case (mode_q)
            IDLE: begin
                if (start) begin
                    snap_d  = sel_bus;
                    phase_d = '0;
                    mode_d  = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    outPhase_d = phase_q;
                    if (code == '0) begin
                        data_d = '0;
                    end else if (codeInRange) begin
                        data_d  = srcSel;
                        valid_d = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end

                    // A start on the final phase chains straight into the next instruction.
                    if (phase_q == LAST_PHASE) begin
                        done_d  = 1'b1;
                        phase_d = '0;
                        if (start) begin
                            snap_d = sel_bus;
                        end else begin
                            mode_d = IDLE;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: begin
                mode_d  = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q     <= IDLE;
            phase_q    <= '0;
            snap_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            outPhase_q <= '0;
            done_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            snap_q     <= snap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            outPhase_q <= outPhase_d;
            done_q     <= done_d;
            bad_q      <= bad_d;
        end
    end

    assign busy      = (mode_q == RUN);
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_phase = outPhase_q;
    assign done      = done_q;
    assign bad_sel   = bad_q;

endmodule
